// File: rtl/gsn_mul_share_ctrl_if.sv
// gsn_mul_share_ctrl_if
//   Bundles the requester, multiplier and result channels of the shared-multiplier
//   controller. The controller uses the slave modport; whatever surrounds it (the
//   filter stages, the multiplier instance and the result consumer) uses master.
//
//   req_valid/req_a/req_b/req_ready  NUM_REQ operand channels, 11-bit signed operands
//                                    packed with requester i at [11i+10:11i]
//   mul_ce/mul_din0/mul_din1         drive the shared pipelined multiplier
//   mul_dout                         22-bit signed product from the multiplier
//   res_valid/res_ready/res_data/    product channel, labelled with the issuing
//   res_id                           requester
//   busy                             any product still in flight
interface gsn_mul_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*11-1:0] req_a;
    logic [NUM_REQ*11-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  mul_ce;
    logic [10:0]           mul_din0;
    logic [10:0]           mul_din1;
    logic [21:0]           mul_dout;

    logic                  res_valid;
    logic                  res_ready;
    logic [21:0]           res_data;
    logic [ID_W-1:0]       res_id;

    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, res_ready,
        output req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_data, res_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_dout, res_ready,
        input  req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/gsn_mul_share_ctrl.sv
// gsn_mul_share_ctrl
//   Shares one pipelined signed 11x11->22 multiplier (no reset, global clock enable,
//   MUL_LAT-edge latency) among NUM_REQ requesters. At most one operand pair is granted
//   per cycle in round-robin order; the requester ID rides alongside the product in a
//   MUL_LAT-deep tag pipeline so results come back on one valid/ready channel labelled
//   with their origin. Result backpressure freezes the whole datapath via mul_ce.
//
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset
//   bus       gsn_mul_share_ctrl_if.slave (requesters, multiplier, result, busy)
module gsn_mul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    gsn_mul_share_ctrl_if.slave   bus
);

    logic [MUL_LAT-1:0] tag_v;
    logic [ID_W-1:0]    tag_id [MUL_LAT];
    logic [ID_W-1:0]    rr;

    logic               stall;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    scan_idx;
    logic [10:0]        din0;
    logic [10:0]        din1;

    // The multiplier holds its pipeline while ce is low, so a waiting result stays on
    // mul_dout and everything upstream must hold too.
    assign stall = tag_v[MUL_LAT-1] & ~bus.res_ready;

    // Round-robin scan starting at rr, wrapping at NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr) + i) % NUM_REQ);
            if (!grant_any && bus.req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx;
            end
        end
        if (stall) begin
            grant_any = 1'b0;
            grant_id  = '0;
        end
        if (grant_any) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    // One-hot operand mux; zero operands when nothing is granted.
    always_comb begin
        din0 = '0;
        din1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                din0 = din0 | bus.req_a[11*i +: 11];
                din1 = din1 | bus.req_b[11*i +: 11];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr    <= '0;
            tag_v <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else if (!stall) begin
            if (grant_any) begin
                rr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            for (int k = MUL_LAT - 1; k > 0; k--) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            tag_v[0]  <= grant_any;
            tag_id[0] <= grant_id;
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.mul_ce    = ~stall;
    assign bus.mul_din0  = din0;
    assign bus.mul_din1  = din1;
    assign bus.res_valid = tag_v[MUL_LAT-1];
    assign bus.res_id    = tag_id[MUL_LAT-1];
    assign bus.res_data  = bus.mul_dout;
    assign bus.busy      = |tag_v;

endmodule
